// File: rtl/dly_tap_aligner.sv
// Delay-line tap scanner: steps tap_sel, majority-votes the registered line
// output at each tap and locks on the first 0->1 transition.
module dly_tap_aligner #(
  parameter  int TAPS    = 16,
  parameter  int SETTLE  = 4,
  parameter  int SAMPLES = 8,
  localparam int TAP_W   = (TAPS > 2) ? $clog2(TAPS) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic             sample_i,
  output logic [TAP_W-1:0] tap_sel,
  output logic             busy,
  output logic             done,
  output logic             locked,
  output logic             err,
  output logic [TAP_W-1:0] edge_tap
);

  localparam int CNT_MAX = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ONES_W  = $clog2(SAMPLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM, S_DECIDE} state_t;

  state_t            r_state, w_state;
  logic [TAP_W-1:0]  r_tap, w_tap, r_edge, w_edge;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [ONES_W-1:0] r_ones, w_ones;
  logic              r_prev, w_prev;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_locked, w_locked;
  logic              r_err, w_err;
  logic              w_v;

  // Strict majority: a tie reads as 0.
  assign w_v = (r_ones > ONES_W'(SAMPLES / 2));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_tap    <= '0;
      r_edge   <= '0;
      r_cnt    <= '0;
      r_ones   <= '0;
      r_prev   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_tap    <= w_tap;
      r_edge   <= w_edge;
      r_cnt    <= w_cnt;
      r_ones   <= w_ones;
      r_prev   <= w_prev;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_locked <= w_locked;
      r_err    <= w_err;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_tap    = r_tap;
    w_edge   = r_edge;
    w_cnt    = r_cnt;
    w_ones   = r_ones;
    w_prev   = r_prev;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_locked = r_locked;
    w_err    = r_err;
    if (r_state == S_IDLE) begin
      if (start && !abort) begin
        w_locked = 1'b0;
        w_err    = 1'b0;
        w_tap    = '0;
        w_busy   = 1'b1;
        w_cnt    = CNT_W'(SETTLE - 1);
        w_state  = S_SETTLE;
      end
    end else if (abort) begin
      // Abort wins over any DECIDE outcome in the same cycle.
      w_state  = S_IDLE;
      w_tap    = '0;
      w_busy   = 1'b0;
      w_locked = 1'b0;
      w_err    = 1'b0;
    end else begin
      case (r_state)
        S_SETTLE: begin
          if (r_cnt == '0) begin
            w_ones  = '0;
            w_cnt   = CNT_W'(SAMPLES - 1);
            w_state = S_ACCUM;
          end else begin
            w_cnt = r_cnt - CNT_W'(1);
          end
        end
        S_ACCUM: begin
          w_ones = r_ones + ONES_W'(sample_i);
          if (r_cnt == '0) w_state = S_DECIDE;
          else             w_cnt   = r_cnt - CNT_W'(1);
        end
        S_DECIDE: begin
          if (r_tap != '0 && !r_prev && w_v) begin
            w_locked = 1'b1;
            w_edge   = r_tap;
            w_done   = 1'b1;
            w_busy   = 1'b0;
            w_state  = S_IDLE;
          end else if (r_tap == TAP_W'(TAPS - 1)) begin
            w_err   = 1'b1;
            w_tap   = '0;
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_state = S_IDLE;
          end else begin
            w_prev  = w_v;
            w_tap   = r_tap + TAP_W'(1);
            w_cnt   = CNT_W'(SETTLE - 1);
            w_state = S_SETTLE;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  assign tap_sel  = r_tap;
  assign busy     = r_busy;
  assign done     = r_done;
  assign locked   = r_locked;
  assign err      = r_err;
  assign edge_tap = r_edge;

endmodule
